// File: rtl/bist_session_sequencer.sv
// Multi-session BIST campaign sequencer: launches one controller session per seed index,
// checks each MISR signature against its golden value and aggregates a per-session fail mask.
module bist_session_sequencer #(
  parameter int                     NSESS   = 4,
  parameter int                     SIG_W   = 16,
  parameter logic [NSESS*SIG_W-1:0] GOLDEN  = '0,
  parameter int                     TIMEOUT = 1023,
  parameter int                     IDX_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             bist_start,
  input  logic             bist_finish,
  input  logic [SIG_W-1:0] misr_sig,
  output logic [IDX_W-1:0] sess_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NSESS-1:0] fail_mask,
  output logic             timeout_err
);

  localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSESS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sess_idx_q, sess_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [NSESS-1:0] fail_mask_q, fail_mask_d;
  logic             timeout_err_q, timeout_err_d;

  function automatic logic [SIG_W-1:0] golden_sig(input logic [IDX_W-1:0] idx);
    logic [SIG_W-1:0] g;
    g = '0;
    for (int i = 0; i < NSESS; i++) begin
      g = (idx == IDX_W'(i)) ? GOLDEN[i*SIG_W +: SIG_W] : g;
    end
    return g;
  endfunction

  function automatic logic [NSESS-1:0] sess_onehot(input logic [IDX_W-1:0] idx);
    logic [NSESS-1:0] m;
    m = '0;
    for (int i = 0; i < NSESS; i++) begin
      m[i] = (idx == IDX_W'(i)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Next-state and datapath updates for the campaign sequencer.
  always_comb begin
    state_d       = state_q;
    sess_idx_d    = sess_idx_q;
    cnt_d         = cnt_q;
    sig_d         = sig_q;
    fail_mask_d   = fail_mask_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LAUNCH;
          fail_mask_d   = '0;
          timeout_err_d = 1'b0;
          sess_idx_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A finish arriving on the timeout cycle still counts as a completed session.
        if (bist_finish) begin
          sig_d   = misr_sig;
          state_d = S_CHECK;
        end else if (cnt_q == TIMEOUT_C) begin
          fail_mask_d   = fail_mask_q | sess_onehot(sess_idx_q);
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CHECK: begin
        if (sig_q != golden_sig(sess_idx_q)) begin
          fail_mask_d = fail_mask_q | sess_onehot(sess_idx_q);
        end else begin
          fail_mask_d = fail_mask_q;
        end
        if (sess_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        sess_idx_d = sess_idx_q + IDX_W'(1);
        state_d    = S_LAUNCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sess_idx_q    <= '0;
      cnt_q         <= '0;
      sig_q         <= '0;
      fail_mask_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sess_idx_q    <= sess_idx_d;
      cnt_q         <= cnt_d;
      sig_q         <= sig_d;
      fail_mask_q   <= fail_mask_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bist_start  = (state_q == S_LAUNCH);
  assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK)  || (state_q == S_GAP);
  assign done        = (state_q == S_DONE);
  assign pass        = done && (fail_mask_q == '0) && !timeout_err_q;
  assign sess_idx    = sess_idx_q;
  assign fail_mask   = fail_mask_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Scoreboard bench for bist_session_sequencer: a responder model answers each launch,
// expected launch indices and campaign results are queued and compared as the DUT produces them.
module tb_bist_session_sequencer;

  localparam int NSESS = 4;
  localparam int SIG_W = 16;
  localparam int IDX_W = 2;
  localparam int TMO   = 20;
  localparam logic [NSESS*SIG_W-1:0] GOLD = 64'h4444_3333_2222_1111;

  logic             clk;
  logic             reset;
  logic             start;
  logic             bist_start;
  logic             bist_finish;
  logic [SIG_W-1:0] misr_sig;
  logic [IDX_W-1:0] sess_idx;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NSESS-1:0] fail_mask;
  logic             timeout_err;

  bist_session_sequencer #(
    .NSESS(NSESS), .SIG_W(SIG_W), .GOLDEN(GOLD), .TIMEOUT(TMO), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bist_start(bist_start),
    .bist_finish(bist_finish), .misr_sig(misr_sig), .sess_idx(sess_idx),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cycle    = 0;

  int          resp_delay [NSESS];
  logic [15:0] resp_sig   [NSESS];
  int          cd          = -1;
  int          gap_cd      = -1;
  int          resp_idx    = 0;
  int          last_launch = 0;
  int          last_finish = 0;
  bit          spur_en     = 1'b0;
  bit          start_req   = 1'b0;
  bit          reset_req   = 1'b0;
  bit          finish_req  = 1'b0;

  int         exp_idx_q[$];
  logic [5:0] exp_res_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // One clock: observe DUT at the falling edge, then drive inputs for this cycle.
  task automatic step();
    bit launched_now;
    launched_now = 1'b0;
    @(negedge clk);
    cycle++;
    if (bist_start) begin
      if (exp_idx_q.size() == 0) begin
        check("extra_launch", 32'd1, 32'd0);
      end else begin
        check("launch_idx", 32'(sess_idx), 32'(exp_idx_q.pop_front()));
      end
      resp_idx     = int'(sess_idx);
      cd           = resp_delay[resp_idx];
      last_launch  = cycle;
      launched_now = 1'b1;
    end
    bist_finish = 1'b0;
    misr_sig    = 16'h0000;
    start       = 1'b0;
    reset       = 1'b0;
    if (start_req) begin
      start     = 1'b1;
      start_req = 1'b0;
    end
    if (gap_cd > 0) begin
      gap_cd--;
      if (gap_cd == 0) begin
        bist_finish = 1'b1;
        misr_sig    = 16'hBAD0;
        gap_cd      = -1;
      end
    end
    if (!launched_now && cd > 0) begin
      cd--;
      if (cd == 0) begin
        bist_finish = 1'b1;
        misr_sig    = resp_sig[resp_idx];
        last_finish = cycle;
        cd          = -1;
        if (spur_en) gap_cd = 2;
      end else if (spur_en && cd == 5) begin
        start = 1'b1;
      end
    end
    if (finish_req) begin
      bist_finish = 1'b1;
      misr_sig    = 16'h1111;
      finish_req  = 1'b0;
    end
    if (reset_req) begin
      reset     = 1'b1;
      reset_req = 1'b0;
      cd        = -1;
      gap_cd    = -1;
    end
  endtask

  task automatic set_default_cfg();
    for (int i = 0; i < NSESS; i++) begin
      resp_delay[i] = 10;
      resp_sig[i]   = GOLD[i*SIG_W +: SIG_W];
    end
    spur_en = 1'b0;
  endtask

  task automatic run_campaign(input int n_launch, input logic [5:0] exp_res, input bit tmo_case);
    logic [5:0] r;
    for (int i = 0; i < n_launch; i++) exp_idx_q.push_back(i);
    exp_res_q.push_back(exp_res);
    start_req = 1'b1;
    step();
    step();
    check("start_latency", 32'(bist_start), 32'd1);
    check("restart_clear", 32'({timeout_err, fail_mask}), 32'd0);
    for (int k = 0; k < 400 && !done; k++) step();
    check("done_reached", 32'(done), 32'd1);
    r = exp_res_q.pop_front();
    if (done) begin
      check("result", 32'({pass, timeout_err, fail_mask}), 32'(r));
      if (tmo_case) check("timeout_latency", 32'(cycle - last_launch), 32'd22);
      else          check("done_latency", 32'(cycle - last_finish), 32'd2);
    end
    check("launches_left", 32'(exp_idx_q.size()), 32'd0);
    exp_idx_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bist_finish = 1'b0; misr_sig = 16'h0000;
    set_default_cfg();
    @(negedge clk);
    @(negedge clk);
    reset_req = 1'b1;
    step();
    step();
    check("reset_state",
          32'({bist_start, busy, done, pass, timeout_err, fail_mask, sess_idx}), 32'd0);

    // Clean pass campaign.
    run_campaign(4, {1'b1, 1'b0, 4'b0000}, 1'b0);

    // Session 2 mismatch; restart straight from DONE.
    resp_sig[2] = 16'hDEAD;
    run_campaign(4, {1'b0, 1'b0, 4'b0100}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) finish_req = 1'b1;
      step();
      check("done_hold", 32'({done, pass, timeout_err, fail_mask}), 32'({1'b1, 1'b0, 1'b0, 4'b0100}));
    end

    // Restart clears the old mask; spurious start in WAIT and finish in GAP are ignored.
    set_default_cfg();
    spur_en = 1'b1;
    run_campaign(4, {1'b1, 1'b0, 4'b0000}, 1'b0);
    spur_en = 1'b0;

    // Session 1 never finishes: abort after 21 WAIT cycles, session 2 not launched.
    set_default_cfg();
    resp_delay[1] = -1;
    run_campaign(2, {1'b0, 1'b1, 4'b0010}, 1'b1);
    for (int k = 0; k < 30; k++) step();
    check("no_late_launch", 32'(exp_idx_q.size()), 32'd0);

    // Finish coincides with counter==TIMEOUT in session 0.
    set_default_cfg();
    resp_delay[0] = 21;
    resp_delay[3] = 21;
    run_campaign(4, {1'b1, 1'b0, 4'b0000}, 1'b0);

    // Reset during WAIT of session 2, then a clean campaign.
    set_default_cfg();
    for (int i = 0; i < 3; i++) exp_idx_q.push_back(i);
    start_req = 1'b1;
    step();
    for (int k = 0; k < 200 && !(bist_start && sess_idx == 2'd2); k++) step();
    check("reached_sess2", 32'({bist_start, sess_idx}), 32'({1'b1, 2'd2}));
    for (int k = 0; k < 3; k++) step();
    check("in_wait_before_reset", 32'({busy, bist_start}), 32'({1'b1, 1'b0}));
    reset_req = 1'b1;
    step();
    step();
    check("reset_midrun",
          32'({bist_start, busy, done, pass, timeout_err, fail_mask, sess_idx}), 32'd0);
    exp_idx_q.delete();
    finish_req = 1'b1;
    step();
    step();
    check("idle_finish_ignored", 32'({busy, done, bist_start, fail_mask}), 32'd0);
    run_campaign(4, {1'b1, 1'b0, 4'b0000}, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
